// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared state encoding and widths for the pong match sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } pong_state_t;

  localparam int SCORE_W = 4;
  localparam int SPEED_W = 2;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

endpackage

`default_nettype wire

// File: rtl/frame_tick.sv
// ============================================================================
// frame_tick : one-cycle registered strobe on the first clock of x==0,y==FRAME_Y
// Revision   : 1.0
// ============================================================================
`default_nettype none

module frame_tick
  import pong_pkg::*;
#(
  parameter int FRAME_Y = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           tick
);

  logic match;
  logic match_d;

  assign match = (x == '0) && (y == Y_W'(FRAME_Y));

  // Rising edge only, so a raster that stalls on the boundary still ticks once.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_d <= 1'b0;
      tick    <= 1'b0;
    end else begin
      match_d <= match;
      tick    <= match & ~match_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// pong_game_ctrl : match FSM, scores, serve direction and step/serve commands.
//                  Optional ball speed-up on paddle hits: PONG_CTRL_SPEEDUP_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int FRAME_Y          = 480,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 30,
  parameter int WIN_SCORE        = 9,
  parameter int HITS_PER_SPEEDUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               start,
  input  logic               hit,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               step,
  output logic               serve,
  output logic               serve_dir,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 0) ? $clog2(MAX_FRAMES + 1) : 1;

  pong_state_t      cur;
  pong_state_t      nxt;
  logic             tick;
  logic             start_d;
  logic             start_rise;
  logic [CNT_W-1:0] frame_cnt;
  logic             win;

  frame_tick #(.FRAME_Y(FRAME_Y)) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .tick (tick)
  );

  assign start_rise = start & ~start_d;
  assign win        = (score_l == SCORE_W'(WIN_SCORE)) || (score_r == SCORE_W'(WIN_SCORE));

  always_ff @(posedge clk) begin
    if (rst) cur <= ST_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE:  if (start_rise) nxt = ST_SERVE;
      ST_SERVE: if (tick && frame_cnt == CNT_W'(SERVE_FRAMES - 1)) nxt = ST_PLAY;
      ST_PLAY:  if (miss_l || miss_r) nxt = ST_POINT;
      ST_POINT: if (tick && frame_cnt == CNT_W'(POINT_FRAMES - 1)) nxt = win ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start_rise) nxt = ST_SERVE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    step      = tick && (cur == ST_PLAY);
    game_over = (cur == ST_OVER);
    state     = cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d   <= 1'b0;
      serve     <= 1'b0;
      frame_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      serve_dir <= 1'b1;
    end else begin
      start_d <= start;
      // serve lines up with the first cycle that state reads SERVE
      serve   <= (nxt == ST_SERVE) && (cur != ST_SERVE);
      if (nxt != cur)  frame_cnt <= '0;
      else if (tick)   frame_cnt <= frame_cnt + CNT_W'(1);
      case (cur)
        ST_IDLE: if (start_rise) serve_dir <= 1'b1;
        ST_PLAY: begin
          if (miss_l && !miss_r) begin
            score_r   <= score_r + SCORE_W'(1);
            serve_dir <= 1'b0;
          end else if (miss_r && !miss_l) begin
            score_l   <= score_l + SCORE_W'(1);
            serve_dir <= 1'b1;
          end
        end
        ST_OVER: if (start_rise) begin
          score_l   <= '0;
          score_r   <= '0;
          serve_dir <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PONG_CTRL_SPEEDUP_EN
  localparam int HIT_W = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;

  logic [HIT_W-1:0] hit_cnt;

  always_ff @(posedge clk) begin
    if (rst || serve) begin
      hit_cnt <= '0;
      speed   <= SPEED_W'(1);
    end else if (cur == ST_PLAY && hit) begin
      if (hit_cnt == HIT_W'(HITS_PER_SPEEDUP - 1)) begin
        hit_cnt <= '0;
        if (speed != SPEED_W'(3)) speed <= speed + SPEED_W'(1);
      end else begin
        hit_cnt <= hit_cnt + HIT_W'(1);
      end
    end
  end
`else
  logic unused_hit;

  assign speed      = SPEED_W'(1);
  assign unused_hit = hit ^ (HITS_PER_SPEEDUP == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// tb_pong_game_ctrl : randomized self-checking bench with a rule-level match model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;

  localparam int FY  = 480;
  localparam int SF  = 2;
  localparam int PF  = 2;
  localparam int WIN = 4;
  localparam int HPS = 2;

  logic       clk = 1'b0;
  logic       rst, start, hit, miss_l, miss_r;
  logic [9:0] x;
  logic [8:0] y;
  logic       step, serve, serve_dir, game_over;
  logic [1:0] speed;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int step_seen = 0;
  int serve_seen = 0;

  // rule-level match model
  int m_sl, m_sr, m_hits;
  logic m_dir;
  bit m_over;

  pong_game_ctrl #(
    .FRAME_Y(FY), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
    .WIN_SCORE(WIN), .HITS_PER_SPEEDUP(HPS)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .start(start), .hit(hit),
    .miss_l(miss_l), .miss_r(miss_r), .step(step), .serve(serve),
    .serve_dir(serve_dir), .speed(speed), .score_l(score_l), .score_r(score_r),
    .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step)  step_seen++;
    if (serve) serve_seen++;
  end

  function automatic int exp_speed();
`ifdef PONG_CTRL_SPEEDUP_EN
    return (1 + m_hits / HPS > 3) ? 3 : 1 + m_hits / HPS;
`else
    return 1;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_raster();
    x = 10'($urandom_range(1, 799));
    y = 9'($urandom_range(0, 511));
  endtask

  task automatic run_frame(input int hold);
    x = 10'd0;
    y = 9'(FY);
    repeat (hold) cyc();
    idle_raster();
    repeat ($urandom_range(2, 6)) cyc();
  endtask

  task automatic run_frames(input int n);
    repeat (n) run_frame($urandom_range(1, 3));
  endtask

  task automatic pulse_hit_play();
    hit = 1'b1; cyc(); hit = 1'b0;
    m_hits++;
    cyc();
    chk_cnt++; if (speed !== 2'(exp_speed())) $display("FAIL hit_speed got %0d want %0d", speed, exp_speed()); else pass_cnt++;
  endtask

  task automatic do_point(input bit ml, input bit mr, input bit with_tick);
    int sv;
    if (with_tick) begin
      x = 10'd0; y = 9'(FY);
      cyc();
      chk_cnt++; if (step !== 1'b1) $display("FAIL tick_with_miss_step got %0b want 1", step); else pass_cnt++;
    end
    miss_l = ml; miss_r = mr;
    cyc();
    miss_l = 1'b0; miss_r = 1'b0;
    idle_raster();
    if (ml && !mr) begin m_sr++; m_dir = 1'b0; end
    else if (mr && !ml) begin m_sl++; m_dir = 1'b1; end
    m_over = (m_sl == WIN) || (m_sr == WIN);
    chk_cnt++; if (state !== 3'd3) $display("FAIL point_state got %0d want 3", state); else pass_cnt++;
    chk_cnt++; if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr))
      $display("FAIL point_scores got %0d-%0d want %0d-%0d", score_l, score_r, m_sl, m_sr); else pass_cnt++;
    chk_cnt++; if (serve_dir !== m_dir) $display("FAIL point_dir got %0b want %0b", serve_dir, m_dir); else pass_cnt++;
    hit = 1'b1; cyc(); hit = 1'b0;
    sv = serve_seen;
    run_frames(PF);
    if (m_over) begin
      chk_cnt++; if (state !== 3'd4 || game_over !== 1'b1)
        $display("FAIL over_entry got state %0d go %0b want 4 1", state, game_over); else pass_cnt++;
      chk_cnt++; if (serve_seen !== sv) $display("FAIL over_no_serve got %0d want %0d", serve_seen, sv); else pass_cnt++;
    end else begin
      m_hits = 0;
      chk_cnt++; if (state !== 3'd1) $display("FAIL reserve_state got %0d want 1", state); else pass_cnt++;
      chk_cnt++; if (serve_seen !== sv + 1) $display("FAIL reserve_pulse got %0d want %0d", serve_seen - sv, 1); else pass_cnt++;
      hit = 1'b1; cyc(); hit = 1'b0;
      chk_cnt++; if (speed !== 2'(exp_speed())) $display("FAIL serve_speed got %0d want %0d", speed, exp_speed()); else pass_cnt++;
      run_frames(SF);
      chk_cnt++; if (state !== 3'd2) $display("FAIL replay_state got %0d want 2", state); else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    idle_raster();
    repeat (3) cyc();
    chk_cnt++; if (step !== 1'b0 || serve !== 1'b0) $display("FAIL reset_pulses got %0b%0b want 00", step, serve); else pass_cnt++;
    chk_cnt++; if (serve_dir !== 1'b1) $display("FAIL reset_dir got %0b want 1", serve_dir); else pass_cnt++;
    chk_cnt++; if (speed !== 2'd1) $display("FAIL reset_speed got %0d want 1", speed); else pass_cnt++;
    chk_cnt++; if (score_l !== 4'd0 || score_r !== 4'd0) $display("FAIL reset_scores got %0d-%0d want 0-0", score_l, score_r); else pass_cnt++;
    chk_cnt++; if (state !== 3'd0 || game_over !== 1'b0) $display("FAIL reset_state got %0d %0b want 0 0", state, game_over); else pass_cnt++;
    rst = 1'b0;
    cyc();
    run_frames(3);
    chk_cnt++; if (step_seen !== 0 || serve_seen !== 0) $display("FAIL idle_quiet got %0d steps %0d serves want 0 0", step_seen, serve_seen); else pass_cnt++;
    chk_cnt++; if (state !== 3'd0) $display("FAIL idle_state got %0d want 0", state); else pass_cnt++;
  endtask

  task automatic test_start_and_serve();
    int s0;
    start = 1'b1;
    cyc();
    m_sl = 0; m_sr = 0; m_dir = 1'b1; m_hits = 0;
    chk_cnt++; if (state !== 3'd1 || serve !== 1'b1 || serve_dir !== 1'b1)
      $display("FAIL start_serve got state %0d serve %0b dir %0b want 1 1 1", state, serve, serve_dir); else pass_cnt++;
    cyc();
    chk_cnt++; if (serve !== 1'b0) $display("FAIL serve_width got %0b want 0", serve); else pass_cnt++;
    s0 = step_seen;
    run_frame(3);
    chk_cnt++; if (state !== 3'd1) $display("FAIL serve_wait got %0d want 1", state); else pass_cnt++;
    run_frame(2);
    chk_cnt++; if (state !== 3'd2) $display("FAIL serve_done got %0d want 2", state); else pass_cnt++;
    chk_cnt++; if (serve_seen !== 1 || step_seen !== s0) $display("FAIL serve_counts got %0d serves %0d steps want 1 0", serve_seen, step_seen - s0); else pass_cnt++;
    start = 1'b0;
  endtask

  task automatic test_step();
    for (int i = 0; i < 6; i++) begin
      int s0, hold;
      hold = (i == 0) ? 5 : $urandom_range(1, 5);
      s0 = step_seen;
      x = 10'd0; y = 9'(FY);
      cyc();
      chk_cnt++; if (step !== 1'b1) $display("FAIL step_latency got %0b want 1", step); else pass_cnt++;
      if (hold > 1) begin
        cyc();
        chk_cnt++; if (step !== 1'b0) $display("FAIL step_width got %0b want 0", step); else pass_cnt++;
        repeat (hold - 2) cyc();
      end
      idle_raster();
      repeat ($urandom_range(2, 6)) cyc();
      chk_cnt++; if (step_seen !== s0 + 1) $display("FAIL step_per_frame got %0d want 1", step_seen - s0); else pass_cnt++;
    end
  endtask

  task automatic test_speed();
    repeat (6) pulse_hit_play();
  endtask

  task automatic test_miss_l();
    do_point(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_point(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_midgame_reset();
    repeat (3) do_point(1'b0, 1'b1, 1'b0);
    chk_cnt++; if (score_l !== 4'd3 || score_r !== 4'd1) $display("FAIL pre_reset_scores got %0d-%0d want 3-1", score_l, score_r); else pass_cnt++;
    rst = 1'b1;
    x = 10'd0; y = 9'(FY);
    cyc();
    chk_cnt++; if (state !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0)
      $display("FAIL midgame_reset got state %0d scores %0d-%0d want 0 0-0", state, score_l, score_r); else pass_cnt++;
    chk_cnt++; if (serve !== 1'b0 || step !== 1'b0) $display("FAIL midgame_pulses got %0b%0b want 00", serve, step); else pass_cnt++;
    rst = 1'b0;
    idle_raster();
    cyc();
  endtask

  task automatic test_random_match();
    start = 1'b1;
    cyc();
    m_sl = 0; m_sr = 0; m_dir = 1'b1; m_hits = 0; m_over = 1'b0;
    chk_cnt++; if (state !== 3'd1 || serve !== 1'b1) $display("FAIL match_start got state %0d serve %0b want 1 1", state, serve); else pass_cnt++;
    run_frames(SF);
    for (int i = 0; i < 60 && !m_over; i++) begin
      int kind;
      repeat ($urandom_range(0, 3)) pulse_hit_play();
      kind = $urandom_range(0, 4);
      do_point(kind <= 1 || kind == 4, kind == 2 || kind == 3 || kind == 4, 1'($urandom_range(0, 1)));
    end
    for (int j = 0; j < 8 && !m_over; j++) do_point(1'b0, 1'b1, 1'b0);
    repeat (5) cyc();
    chk_cnt++; if (state !== 3'd4 || game_over !== 1'b1) $display("FAIL held_start got state %0d go %0b want 4 1", state, game_over); else pass_cnt++;
    start = 1'b0;
    repeat (2) cyc();
    chk_cnt++; if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr))
      $display("FAIL over_frozen got %0d-%0d want %0d-%0d", score_l, score_r, m_sl, m_sr); else pass_cnt++;
    start = 1'b1;
    cyc();
    chk_cnt++; if (state !== 3'd1 || serve !== 1'b1 || serve_dir !== 1'b1)
      $display("FAIL restart got state %0d serve %0b dir %0b want 1 1 1", state, serve, serve_dir); else pass_cnt++;
    chk_cnt++; if (score_l !== 4'd0 || score_r !== 4'd0) $display("FAIL restart_scores got %0d-%0d want 0-0", score_l, score_r); else pass_cnt++;
    start = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_start_and_serve();
    test_step();
    test_speed();
    test_miss_l();
    test_simultaneous();
    test_midgame_reset();
    test_random_match();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the pong datapath. Derives a once-per-frame update strobe from the VGA raster position and runs the match state machine (idle, serve countdown, play, point pause, game over). Owns both scores and the serve direction, and commands the ball/paddle datapath through `step` and `serve` pulses. Sits between the VGA timing generator and the pong ball/paddle datapath.

## Interface
Parameters:
- `FRAME_Y`, default 480: raster line whose x==0 pixel marks the frame boundary (first vblank line).
- `SERVE_FRAMES`, default 60: frame ticks spent in SERVE before play.
- `POINT_FRAMES`, default 30: frame ticks spent in POINT after a miss.
- `WIN_SCORE`, default 9: score that ends the match (1..15).
- `HITS_PER_SPEEDUP`, default 4: paddle hits per speed step (only with speed-up compiled in).

Ports:
- `clk` in 1: single clock, pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `x` in 10: current raster column.
- `y` in 9: current raster row.
- `start` in 1: debounced start button, level.
- `hit` in 1: one-cycle pulse from the datapath on a paddle collision.
- `miss_l`, `miss_r` in 1: one-cycle pulses when the ball passes the left/right edge.
- `step` out 1: one-cycle pulse; datapath advances ball and paddles once.
- `serve` out 1: one-cycle pulse; datapath recentres the ball.
- `serve_dir` out 1: 0 = ball moves left, 1 = ball moves right.
- `speed` out 2: ball pixels per step, 1..3.
- `score_l`, `score_r` out 4: player scores.
- `state` out 3: FSM state encoding.
- `game_over` out 1: high while in OVER.

## Operation
- Frame tick: internal `tick` is registered. It pulses for one cycle on the rising edge of (x==0 && y==FRAME_Y), so at most one tick per frame even if x/y hold for several clocks.
- `start` is rising-edge detected. Holding it does not retrigger.
- States, encoded IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4:
  - IDLE: scores held at 0, no step. A start edge sets serve_dir=1, pulses serve and moves to SERVE.
  - SERVE: frame counter cleared on entry. After SERVE_FRAMES ticks, move to PLAY. No step pulses.
  - PLAY: `step` = tick.
    - miss_l: score_r+1, serve_dir=0, move to POINT.
    - miss_r: score_l+1, serve_dir=1, move to POINT.
    - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, move to POINT.
  - POINT: after POINT_FRAMES ticks:
    - if either score equals WIN_SCORE, move to OVER;
    - otherwise pulse serve and move to SERVE.
  - OVER: game_over=1, scores frozen. A start edge clears both scores, sets serve_dir=1, pulses serve and moves to SERVE.
- hit, miss_l and miss_r are ignored outside PLAY. A start edge is ignored outside IDLE and OVER.
- Scores are 4-bit. With WIN_SCORE ≤ 15 they never wrap.
- Frame counter width is clog2(max(SERVE_FRAMES, POINT_FRAMES)+1). It counts only on tick.

## Timing
- Reset values: step=0, serve=0, serve_dir=1, speed=1, score_l=score_r=0, state=IDLE, game_over=0, all counters 0.
- tick and step assert 1 cycle after the raster condition first becomes true.
- serve asserts in the first cycle that state reads SERVE. It lasts exactly one cycle.
- Score and state updates appear 1 cycle after the miss pulse.
- The tick that completes a count causes the transition on the next edge. SERVE therefore lasts SERVE_FRAMES ticks (±1 partial frame).
- A tick in the same cycle as a miss still produces step. The state change takes effect on the following cycle.
- rst mid-game returns to IDLE on the next edge and drops any pending pulse.

## Configuration
- `PONG_CTRL_SPEEDUP_EN` defined:
  - a hit counter increments on each hit in PLAY;
  - every HITS_PER_SPEEDUP hits, speed increments, saturating at 3, and the counter clears;
  - speed and the hit counter reset to 1/0 on every serve pulse.
- Not defined: speed is constant 1, hit is ignored, no hit counter exists.

## Structure
- Package `pong_pkg`:
  - state enum `pong_state_t` (3-bit, encodings above);
  - score width constant `SCORE_W=4`, speed width `SPEED_W=2`;
  - raster widths `X_W=10`, `Y_W=9`.
- Sub-module `frame_tick`: edge-detected raster match producing `tick`, parameterised by FRAME_Y. The FSM, counters and scores live in pong_game_ctrl.

## Test plan
- Reset, then raster sweep: all outputs at reset values; no step in IDLE; after the start edge, exactly one serve pulse with serve_dir=1 and state=1.
- Small parameters (SERVE_FRAMES=2): state=2 after 2 ticks; one step per frame, 1 cycle after x=0,y=FRAME_Y; x/y held 5 cycles still gives one step.
- PLAY, miss_l: score_r=1, serve_dir=0, state=3; after POINT_FRAMES ticks one serve pulse and state=1. Simultaneous miss_l+miss_r leaves scores at 0.
- WIN_SCORE=2, two miss_r events: score_l=2, state=4, game_over=1; held start gives no restart; next start edge gives scores 0 and a serve pulse.
- With PONG_CTRL_SPEEDUP_EN, HITS_PER_SPEEDUP=2, 6 hits: speed goes 1→2→3→3; next serve returns speed to 1. Without the macro, speed stays 1.
- rst asserted in PLAY with score 3–1: next cycle state=0, scores 0, no serve or step pulse.
